// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the I2C codec register responder and its initiator bench:
// FSM encoding, default device address and the 24-bit write-frame layout.
package i2c_codec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEV    = 3'd1,
        ACK_D  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
    localparam logic [3:0] BYTE_BITS        = 4'd8;

    // Frame = {device byte, byte1, byte2}; byte1/byte2 carry {reg_addr, reg_data}
    localparam int FRAME_W      = 24;
    localparam int FRM_DEV_LSB  = 16;
    localparam int FRM_ADDR_LSB = 9;
    localparam int FRM_ADDR_W   = 7;
    localparam int FRM_DATA_LSB = 0;
    localparam int FRM_DATA_W   = 9;

    function automatic logic [7:0] dev_write_byte(input logic [6:0] addr);
        return {addr, 1'b0};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes sclk/sdat into clk and decodes sclk edges plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic swt,
    input  logic i_sclk,
    input  logic i_sdat,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    // [1:0] form the 2-flop synchronizer, [2] holds the previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            r_scl <= '1;
            r_sda <= '1;
        end else begin
            r_scl <= {r_scl[1:0], i_sclk};
            r_sda <= {r_sda[1:0], i_sdat};
        end
    end

    assign o_sda      = r_sda[1];
    assign o_scl_rise =  r_scl[1] & ~r_scl[2];
    assign o_scl_fall = ~r_scl[1] &  r_scl[2];
    assign o_start    =  r_scl[1] &  r_scl[2] &  r_sda[2] & ~r_sda[1];
    assign o_stop     =  r_scl[1] &  r_scl[2] & ~r_sda[2] &  r_sda[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only responder for codec-style 3-byte frames: device byte, then
// {addr[6:0],data[8]} and data[7:0]; presents each completed write as a reg_wr strobe.
module i2c_codec_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  swt,
    input  logic                  sclk,
    inout  wire                   sdat,
    output logic [FRM_ADDR_W-1:0] reg_addr,
    output logic [FRM_DATA_W-1:0] reg_data,
    output logic                  reg_wr,
    output logic                  busy,
    output logic                  nack
);
    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_sync u_bus_sync (
        .clk        (clk),
        .swt        (swt),
        .i_sclk     (sclk),
        .i_sdat     (sdat),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t     r_state, w_state_next;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_ack_clk;    // rising edge of the 9th clock already seen
    logic       r_nack_slot;  // IGNORE is inside the 9th clock of a byte
    logic       r_sda_low;
    logic       w_in_ack, w_byte_done, w_ack_done, w_nack_next, w_wr_next;

    assign w_in_ack    = (r_state == ACK_D) || (r_state == ACK_1) || (r_state == ACK_2) ||
                         ((r_state == IGNORE) && r_nack_slot);
    assign w_byte_done = w_scl_fall && (r_bit_cnt == BYTE_BITS) && !w_in_ack;
    assign w_ack_done  = w_scl_fall && w_in_ack && r_ack_clk;

    always_ff @(posedge clk or negedge swt) begin
        if (!swt) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_nack_next  = 1'b0;
        w_wr_next    = 1'b0;
        if (w_stop) begin
            w_state_next = IDLE;
        end else if (w_start) begin
            w_state_next = DEV;
        end else begin
            case (r_state)
                DEV: if (w_byte_done) begin
                    if (r_shift == dev_write_byte(DEV_ADDR)) begin
                        w_state_next = ACK_D;
                    end else begin
                        w_state_next = IGNORE;
                        w_nack_next  = 1'b1;
                    end
                end
                ACK_D:  if (w_ack_done)  w_state_next = BYTE1;
                BYTE1:  if (w_byte_done) w_state_next = ACK_1;
                ACK_1:  if (w_ack_done)  w_state_next = BYTE2;
                BYTE2:  if (w_byte_done) w_state_next = ACK_2;
                ACK_2: if (w_ack_done) begin
                    w_state_next = IGNORE;
                    w_wr_next    = 1'b1;
                end
                IGNORE: if (w_byte_done) w_nack_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge swt) begin
        if (!swt) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_byte1     <= '0;
            r_ack_clk   <= 1'b0;
            r_nack_slot <= 1'b0;
            r_sda_low   <= 1'b0;
            reg_addr    <= '0;
            reg_data    <= '0;
            reg_wr      <= 1'b0;
            busy        <= 1'b0;
            nack        <= 1'b0;
        end else begin
            r_sda_low <= (w_state_next == ACK_D) || (w_state_next == ACK_1) ||
                         (w_state_next == ACK_2);
            nack      <= w_nack_next;
            reg_wr    <= w_wr_next;
            if (w_wr_next) {reg_addr, reg_data} <= {r_byte1, r_shift};

            if (w_start)     busy <= 1'b1;
            else if (w_stop) busy <= 1'b0;

            if (w_start || w_stop) begin
                r_bit_cnt   <= '0;
                r_ack_clk   <= 1'b0;
                r_nack_slot <= 1'b0;
            end else if (w_ack_done) begin
                r_bit_cnt   <= '0;
                r_ack_clk   <= 1'b0;
                r_nack_slot <= 1'b0;
            end else if (w_byte_done) begin
                if (r_state == BYTE1)        r_byte1     <= r_shift;
                if (w_state_next == IGNORE)  r_nack_slot <= 1'b1;
            end else if (w_scl_rise) begin
                if (w_in_ack) begin
                    r_ack_clk <= 1'b1;
                end else if ((r_state != IDLE) && (r_bit_cnt < BYTE_BITS)) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign sdat = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Initiator-driven bench: frames go through a reference model that queues expected
// writes; an independent monitor checks every reg_wr strobe against that queue.
module tb_i2c_codec_responder;
    import i2c_codec_pkg::*;

    localparam int Q = 160;   // quarter of an I2C bit period

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    logic       clk   = 1'b0;
    logic       swt   = 1'b0;
    logic       sclk  = 1'b1;
    logic       m_sda = 1'b1;
    wire        sdat;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       reg_wr;
    logic       busy;
    logic       nack;

    int   n_vec = 0;
    int   n_err = 0;
    int   nack_seen = 0;
    wr_t  wr_q[$];
    logic [7:0] fb[8];
    logic [6:0] model_addr = '0;
    logic [8:0] model_data = '0;

    assign sdat = m_sda ? 1'bz : 1'b0;
    pullup (sdat);

    always #10 clk = ~clk;

    i2c_codec_responder #(.DEV_ADDR(DEV_ADDR_DEFAULT)) dut (
        .clk      (clk),
        .swt      (swt),
        .sclk     (sclk),
        .sdat     (sdat),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .reg_wr   (reg_wr),
        .busy     (busy),
        .nack     (nack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (nack === 1'b1) nack_seen++;
        if (reg_wr === 1'b1) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e.addr));
                check("wr_data", 32'(reg_data), 32'(e.data));
            end
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q; sclk = 1'b1; #Q; m_sda = 1'b0; #Q; sclk = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; sclk = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; #Q; sclk = 1'b1; #(2*Q); sclk = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_sda = 1'b1; #Q; sclk = 1'b1; #Q;
        ack = (sdat === 1'b0);
        #Q; sclk = 1'b0; #Q;
    endtask

    // Reference model: only a write to address 0x34 is acknowledged, and only its
    // first three bytes; a frame of three or more such bytes yields one register write.
    task automatic run_frame(input int n, input bit do_stop);
        bit   valid;
        logic ack;
        int   nack_exp;
        int   nack_before;
        valid    = (fb[0] == 8'h34);
        nack_exp = 0;
        if (valid && n >= 3) begin
            model_addr = 7'(int'(fb[1]) / 2);
            model_data = 9'((int'(fb[1]) % 2) * 256 + int'(fb[2]));
            wr_q.push_back('{addr: model_addr, data: model_data});
        end
        nack_before = nack_seen;
        i2c_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            bit exp_ack;
            exp_ack = valid && (i < 3);
            send_byte(fb[i], ack);
            check($sformatf("ack_byte%0d_0x%02h", i, fb[i]), 32'(ack), 32'(exp_ack));
            if (!exp_ack) nack_exp++;
        end
        if (do_stop) i2c_stop();
        repeat (8) @(negedge clk);
        #1;
        if (do_stop) check("busy_after_stop", 32'(busy), 32'd0);
        check("nack_pulses", 32'(nack_seen - nack_before), 32'(nack_exp));
        check("wr_drained", 32'(wr_q.size()), 32'd0);
        check("reg_addr_hold", 32'(reg_addr), 32'(model_addr));
        check("reg_data_hold", 32'(reg_data), 32'(model_data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_reg_data"}, 32'(reg_data), 32'd0);
        check({tag, "_reg_wr"},   32'(reg_wr),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_nack"},     32'(nack),     32'd0);
        check({tag, "_sdat"},     32'(sdat),     32'd1);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        swt = 1'b1;
        repeat (4) @(negedge clk);

        fb[0] = 8'h34; fb[1] = 8'h00; fb[2] = 8'h17; run_frame(3, 1);
        fb[0] = 8'h34; fb[1] = 8'h12; fb[2] = 8'h01; run_frame(3, 1);
        fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00; run_frame(3, 1);
        fb[0] = 8'h36;                               run_frame(1, 1);
        fb[0] = 8'h34; fb[1] = 8'h0C;                run_frame(2, 1);
        fb[0] = 8'h34; fb[1] = 8'h0C; fb[2] = 8'h9F; fb[3] = 8'hAA; run_frame(4, 1);
        fb[0] = 8'h34; fb[1] = 8'h55;                run_frame(2, 0);
        fb[0] = 8'h34; fb[1] = 8'hA3; fb[2] = 8'h5C; run_frame(3, 1);

        // Reset in the middle of the third byte aborts the transfer
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h00, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        m_sda = 1'b1;
        @(negedge clk);
        swt = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        swt = 1'b1;
        model_addr = '0;
        model_data = '0;
        repeat (4) @(negedge clk);
        fb[0] = 8'h34; fb[1] = 8'h00; fb[2] = 8'h17; run_frame(3, 1);

        for (int f = 0; f < 12; f++) begin
            int n;
            n = int'($urandom_range(1, 5));
            fb[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom);
            for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
            run_frame(n, $urandom_range(0, 3) != 0);
        end
        i2c_stop();
        repeat (8) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C device address the block answers to (written on the bus as 0x34).
REQ-002 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-003 SHALL have port swt, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port sclk, input, 1, I2C serial clock from the initiator.
REQ-005 SHALL have port sdat, inout, 1, I2C serial data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-006 SHALL have port reg_addr, output, 7, register address of the last accepted write.
REQ-007 SHALL have port reg_data, output, 9, register data of the last accepted write.
REQ-008 SHALL have port reg_wr, output, 1, one-clk strobe qualifying reg_addr/reg_data.
REQ-009 SHALL have port busy, output, 1, high from detected START to detected STOP.
REQ-010 SHALL have port nack, output, 1, one-clk pulse when a byte is NACKed.

Function
REQ-011 SHALL pass sclk and sdat through 2-flop synchronizers on clk; all bus events SHALL be decoded from the synchronized values only.
REQ-012 SHALL decode START as a synchronized sdat falling edge while sclk is high, and STOP as a synchronized sdat rising edge while sclk is high.
REQ-013 SHALL sample sdat on each synchronized sclk rising edge, MSB first.
REQ-014 SHALL implement FSM states IDLE, DEV, ACK_D, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-015 Transitions: IDLE->DEV on START; DEV->ACK_D after 8 bits; ACK_D->BYTE1; BYTE1->ACK_1 after 8 bits; ACK_1->BYTE2; BYTE2->ACK_2 after 8 bits; ACK_2->IGNORE. Each ACK state exits on the sclk falling edge that ends the 9th clock.
REQ-016 In DEV, if the received byte is not {DEV_ADDR,1'b0}, the block SHALL NACK (leave sdat released), pulse nack, and go to IGNORE.
REQ-017 SHALL pull sdat low from the sclk falling edge after bit 8 until the sclk falling edge after the ACK clock, in ACK_D, ACK_1 and ACK_2.
REQ-018 SHALL interpret BYTE1 as {reg_addr[6:0], reg_data[8]} and BYTE2 as reg_data[7:0].
REQ-019 SHALL update reg_addr/reg_data and assert reg_wr for exactly one clk cycle on the clk after the falling edge that ends ACK_2.
REQ-020 reg_addr/reg_data SHALL hold their values between writes.
REQ-021 In IGNORE, bytes beyond the third SHALL be NACKed, with one nack pulse per byte and no reg_wr.
REQ-022 STOP in any state SHALL return the FSM to IDLE and release sdat; a STOP before ACK_2 completes SHALL produce no reg_wr.
REQ-023 START (repeated) in any state SHALL reset the bit counter and enter DEV; a partial transfer SHALL be discarded.
REQ-024 A bit counter of 4 bits SHALL count 0..8 and wrap to 0 at each ACK exit.

Reset
REQ-025 While swt=0: FSM=IDLE, sdat released (z), reg_addr=0, reg_data=0, reg_wr=0, busy=0, nack=0, synchronizers=1.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; after release the block SHALL wait for a new START.

Structure
REQ-027 State encoding, DEV_ADDR default and the 24-bit frame field positions SHALL live in a shared package used by i2c_codec_responder and the I2C initiator testbench.
REQ-028 START/STOP/edge detection SHALL be one sub-module, i2c_bus_sync, instantiated once.

Verification
REQ-029 Bytes 0x34,0x00,0x17 then STOP -> three ACKs; reg_wr pulse with reg_addr=0x00, reg_data=0x017.
REQ-030 Bytes 0x34,0x12,0x01 -> reg_addr=0x09, reg_data=0x001; bytes 0x34,0x1E,0x00 -> reg_addr=0x0F, reg_data=0x000.
REQ-031 Byte 0x36 -> sdat never low at the 9th clock; one nack pulse; no reg_wr until STOP plus a new valid frame.
REQ-032 Bytes 0x34,0x0C then STOP -> no reg_wr; reg_addr/reg_data keep their previous values; busy=0 after STOP.
REQ-033 Bytes 0x34,0x0C,0x9F,0xAA -> reg_wr with reg_addr=0x06, reg_data=0x09F; 4th byte NACKed with one nack pulse.
REQ-034 swt low during BYTE2 -> all outputs at reset values with sdat=z; next full frame 0x34,0x00,0x17 is accepted normally.
